// File: rtl/mem_stage.sv
// Memory-access stage: loads and stores against an internal word-addressed
// RAM with a configurable multi-cycle latency. It stalls upstream while an
// access is in flight and registers results into the MEM/WB outputs.
module mem_stage #(
  parameter int ADDR_BITS = 8,
  parameter int LATENCY   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] MEM_aluout,
  input  logic [31:0] MEM_regout,
  input  logic [4:0]  MEM_writeaddress,
  input  logic        MEM_memread,
  input  logic        MEM_memwrite,
  input  logic        MEM_memtoreg,
  input  logic        MEM_regwrite,
  output logic [31:0] WB_aluout,
  output logic [31:0] WB_memdata,
  output logic [4:0]  WB_writeaddress,
  output logic        WB_memtoreg,
  output logic        WB_regwrite,
  output logic        mem_stall,
  output logic        misaligned
);

  typedef enum logic {IDLE, BUSY} state_t;

  // Counter preload on entering BUSY. Counting down to zero covers the
  // remaining LATENCY-1 cycles, the last of which is the completion edge.
  localparam logic [3:0] CNT_INIT = 4'(LATENCY > 1 ? LATENCY - 2 : 0);

  state_t               state, state_next;
  logic [3:0]           cnt, cnt_next;
  logic                 complete;
  logic [31:0]          ram [2**ADDR_BITS];
  logic [ADDR_BITS-1:0] idx;
  logic                 aligned, mem_req, mem_op, misal;
  logic [31:0]          load_data;
  logic                 unused_addr;

  assign idx     = MEM_aluout[ADDR_BITS+1:2];
  assign aligned = (MEM_aluout[1:0] == 2'b00);
  assign mem_req = MEM_memread | MEM_memwrite;
  assign mem_op  = mem_req & aligned;
  assign misal   = mem_req & ~aligned;

  // High address bits are deliberately ignored so addresses wrap modulo RAM size.
  assign unused_addr = ^MEM_aluout[31:ADDR_BITS+2];

  // A store wins over a simultaneous load, and its load data reads as zero.
  assign load_data = (mem_op && MEM_memread && !MEM_memwrite) ? ram[idx] : 32'd0;

  // Next-state, stall and completion decode. The RAM is never consulted here.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    mem_stall  = 1'b0;
    complete   = 1'b1;
    case (state)
      IDLE: begin
        if (mem_op && (LATENCY > 1)) begin
          mem_stall  = 1'b1;
          complete   = 1'b0;
          state_next = BUSY;
          cnt_next   = CNT_INIT;
        end
      end
      BUSY: begin
        if (cnt != 4'd0) begin
          mem_stall = 1'b1;
          complete  = 1'b0;
          cnt_next  = cnt - 4'd1;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 4'd0;
      end
    endcase
  end

  // FSM state and latency counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // MEM/WB register: capture on completion, insert a bubble on stalled edges.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      WB_aluout       <= 32'd0;
      WB_memdata      <= 32'd0;
      WB_writeaddress <= 5'd0;
      WB_memtoreg     <= 1'b0;
      WB_regwrite     <= 1'b0;
      misaligned      <= 1'b0;
    end else if (complete) begin
      WB_aluout       <= MEM_aluout;
      WB_memdata      <= load_data;
      WB_writeaddress <= MEM_writeaddress;
      WB_memtoreg     <= MEM_memtoreg;
      WB_regwrite     <= MEM_regwrite;
      misaligned      <= misal;
    end else begin
      WB_aluout       <= 32'd0;
      WB_memdata      <= 32'd0;
      WB_writeaddress <= 5'd0;
      WB_memtoreg     <= 1'b0;
      WB_regwrite     <= 1'b0;
      misaligned      <= 1'b0;
    end
  end

  // Data RAM: a store commits only at its completion edge; reset aborts it.
  always_ff @(posedge clk) begin
    if (rst_n && complete && mem_op && MEM_memwrite) begin
      ram[idx] <= MEM_regout;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: one instance with LATENCY=2 and one with
// LATENCY=4. The driver pushes per-cycle expectations and the monitor pops
// and compares them on the falling edge.
module tb_mem_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rstn [2];
  logic [31:0] aluout [2];
  logic [31:0] regout [2];
  logic [4:0]  wadr [2];
  logic        mrd [2];
  logic        mwr [2];
  logic        m2r [2];
  logic        rwr [2];
  logic [31:0] o_alu [2];
  logic [31:0] o_md [2];
  logic [4:0]  o_wa [2];
  logic        o_m2r [2];
  logic        o_rw [2];
  logic        o_stall [2];
  logic        o_mis [2];

  mem_stage #(.ADDR_BITS(8), .LATENCY(2)) dut2 (
    .clk(clk), .rst_n(rstn[0]), .MEM_aluout(aluout[0]), .MEM_regout(regout[0]),
    .MEM_writeaddress(wadr[0]), .MEM_memread(mrd[0]), .MEM_memwrite(mwr[0]),
    .MEM_memtoreg(m2r[0]), .MEM_regwrite(rwr[0]), .WB_aluout(o_alu[0]),
    .WB_memdata(o_md[0]), .WB_writeaddress(o_wa[0]), .WB_memtoreg(o_m2r[0]),
    .WB_regwrite(o_rw[0]), .mem_stall(o_stall[0]), .misaligned(o_mis[0]));

  mem_stage #(.ADDR_BITS(8), .LATENCY(4)) dut4 (
    .clk(clk), .rst_n(rstn[1]), .MEM_aluout(aluout[1]), .MEM_regout(regout[1]),
    .MEM_writeaddress(wadr[1]), .MEM_memread(mrd[1]), .MEM_memwrite(mwr[1]),
    .MEM_memtoreg(m2r[1]), .MEM_regwrite(rwr[1]), .WB_aluout(o_alu[1]),
    .WB_memdata(o_md[1]), .WB_writeaddress(o_wa[1]), .WB_memtoreg(o_m2r[1]),
    .WB_regwrite(o_rw[1]), .mem_stall(o_stall[1]), .misaligned(o_mis[1]));

  typedef struct {
    int          cyc;
    logic        cs;
    logic        st;
    logic [31:0] alu;
    logic [31:0] md;
    logic [4:0]  wa;
    logic        m2r;
    logic        rw;
    logic        mis;
  } rec_t;

  rec_t q0[$];
  rec_t q1[$];
  rec_t cur [2];

  int n_tests = 0;
  int n_fail  = 0;

  function automatic rec_t zrec();
    rec_t z;
    z.cyc = 0; z.cs = 1'b1; z.st = 1'b0; z.alu = 32'd0; z.md = 32'd0;
    z.wa = 5'd0; z.m2r = 1'b0; z.rw = 1'b0; z.mis = 1'b0;
    return z;
  endfunction

  task automatic chk(input int d, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL dut%0d cyc %0d %s: got %h, expected %h", d, cyc, name, act, exp);
    end
  endtask

  task automatic compare(input int d, input rec_t e);
    if (e.cs) chk(d, "mem_stall", 32'(o_stall[d]), 32'(e.st));
    chk(d, "WB_aluout", o_alu[d], e.alu);
    chk(d, "WB_memdata", o_md[d], e.md);
    chk(d, "WB_writeaddress", 32'(o_wa[d]), 32'(e.wa));
    chk(d, "WB_memtoreg", 32'(o_m2r[d]), 32'(e.m2r));
    chk(d, "WB_regwrite", 32'(o_rw[d]), 32'(e.rw));
    chk(d, "misaligned", 32'(o_mis[d]), 32'(e.mis));
  endtask

  // Monitor: pop every expectation whose cycle has arrived and compare.
  always @(negedge clk) begin
    rec_t e;
    while (q0.size() != 0 && q0[0].cyc <= cyc) begin
      e = q0.pop_front();
      compare(0, e);
    end
    while (q1.size() != 0 && q1[0].cyc <= cyc) begin
      e = q1.pop_front();
      compare(1, e);
    end
  end

  // One clock: record what this cycle should show, then advance the WB model.
  task automatic step(input int d, input logic cs, input logic st, input rec_t nxt);
    rec_t r;
    r = cur[d];
    r.cyc = cyc;
    r.cs = cs;
    r.st = st;
    if (d == 0) q0.push_back(r); else q1.push_back(r);
    @(posedge clk); #1;
    cur[d] = nxt;
  endtask

  task automatic set_in(input int d, input logic [31:0] a, input logic [31:0] wd, input logic [4:0] w,
                        input logic r, input logic wr, input logic mr2, input logic rwv);
    aluout[d] = a; regout[d] = wd; wadr[d] = w;
    mrd[d] = r; mwr[d] = wr; m2r[d] = mr2; rwr[d] = rwv;
  endtask

  // Present one op, hold it through its stall cycles, and expect its result.
  task automatic op(input int d, input int lat, input logic [31:0] a, input logic [31:0] wd,
                    input logic [4:0] w, input logic r, input logic wr, input logic mr2,
                    input logic rwv, input logic [31:0] md);
    rec_t res;
    logic memop;
    set_in(d, a, wd, w, r, wr, mr2, rwv);
    memop = (r | wr) && (a[1:0] == 2'b00);
    res = zrec();
    res.alu = a; res.md = md; res.wa = w; res.m2r = mr2; res.rw = rwv;
    res.mis = (r | wr) && (a[1:0] != 2'b00);
    if (memop && lat > 1)
      for (int i = 0; i < lat - 1; i++) step(d, 1'b1, 1'b1, zrec());
    step(d, 1'b1, 1'b0, res);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rstn[d] = 1'b0;
      set_in(d, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      cur[d] = zrec();
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    rstn[0] = 1'b1; rstn[1] = 1'b1;

    // Reset with a pending load and regwrite on the inputs clears WB.
    rstn[0] = 1'b0;
    set_in(0, 32'h40, 32'h0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1);
    step(0, 1'b0, 1'b0, zrec());
    step(0, 1'b0, 1'b0, zrec());
    rstn[0] = 1'b1;

    // LATENCY=2 instance.
    op(0, 2, 32'h0000_1234, 32'h0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
    op(0, 2, 32'h10, 32'hDEAD_BEEF, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    op(0, 2, 32'h10, 32'h0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF);
    op(0, 2, 32'h11, 32'hCAFE_F00D, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    op(0, 2, 32'h10, 32'h0, 5'd8, 1'b1, 1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF);
    op(0, 2, 32'h13, 32'h0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0);
    op(0, 2, 32'h14, 32'h55AA_55AA, 5'd2, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0);
    op(0, 2, 32'h14, 32'h0, 5'd4, 1'b1, 1'b0, 1'b1, 1'b1, 32'h55AA_55AA);
    op(0, 2, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

    // LATENCY=4 instance: top word and address wrap.
    op(1, 4, 32'h3FC, 32'hA5A5_0FF0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    op(1, 4, 32'h3FC, 32'h0, 5'd10, 1'b1, 1'b0, 1'b1, 1'b1, 32'hA5A5_0FF0);
    op(1, 4, 32'h7FC, 32'h0, 5'd11, 1'b1, 1'b0, 1'b1, 1'b1, 32'hA5A5_0FF0);
    op(1, 4, 32'h20, 32'h1111_1111, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);

    // Store to 0x20 aborted by reset in its second stalled cycle.
    set_in(1, 32'h20, 32'h2222_2222, 5'd12, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1, 1'b1, 1'b1, zrec());
    rstn[1] = 1'b0;
    step(1, 1'b1, 1'b1, zrec());
    rstn[1] = 1'b1;
    op(1, 4, 32'h20, 32'h0, 5'd13, 1'b1, 1'b0, 1'b1, 1'b1, 32'h1111_1111);
    op(1, 4, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

    @(negedge clk); #1;
    if (q0.size() != 0 || q1.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", q0.size() + q1.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
